// File: rtl/radio_pkg.sv
// Shared radio datapath definitions: fixed-point constants, quantization
// helpers and the fm_demod state encoding.
package radio_pkg;

    localparam int BITS = 10;
    localparam int QUANT_VAL = 1 << BITS;
    localparam logic signed [31:0] QUAD_ONE = 32'sd804;
    localparam logic signed [31:0] QUAD_THREE = 32'sd2412;
    localparam logic signed [31:0] GAIN_DEFAULT = 32'sh000002F5;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        ISSUE,
        WAIT,
        SCALE,
        WRITE
    } state_t;

    function automatic logic signed [31:0] dequantize(input logic signed [31:0] p);
        return p >>> BITS;
    endfunction

    function automatic logic signed [31:0] quantize_i(input logic signed [31:0] v);
        return v * QUANT_VAL;
    endfunction

endpackage

// File: rtl/demod_cmul.sv
// Conjugate product of the previous and current I/Q samples, each partial
// product wrapped to DATA_WIDTH bits and dequantized.
module demod_cmul
    import radio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BITS = radio_pkg::BITS
) (
    input  logic signed [DATA_WIDTH-1:0] prev_real,
    input  logic signed [DATA_WIDTH-1:0] prev_imag,
    input  logic signed [DATA_WIDTH-1:0] cur_real,
    input  logic signed [DATA_WIDTH-1:0] cur_imag,
    output logic signed [DATA_WIDTH-1:0] conj_real,
    output logic signed [DATA_WIDTH-1:0] conj_imag
);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // Product wraps modulo 2^DATA_WIDTH before the shift, as the C model does.
    function automatic sample_t deq_mul(input sample_t a, input sample_t b);
        sample_t prod;
        prod = a * b;
        return prod >>> BITS;
    endfunction

    sample_t neg_prev_imag;

    always_comb begin
        neg_prev_imag = -prev_imag;
        conj_real = deq_mul(prev_real, cur_real) - deq_mul(neg_prev_imag, cur_imag);
        conj_imag = deq_mul(prev_real, cur_imag) + deq_mul(neg_prev_imag, cur_real);
    end

endmodule

// File: rtl/fm_demod.sv
// FM demodulator front end: pops I/Q samples, forms the conjugate product,
// hands it to qarctan and pushes the gain-scaled angle to the audio FIFO.
module fm_demod
    import radio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BITS = radio_pkg::BITS,
    parameter logic signed [DATA_WIDTH-1:0] GAIN = DATA_WIDTH'(GAIN_DEFAULT)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    input  logic                         in_empty,
    output logic                         in_rd_en,
    output logic signed [DATA_WIDTH-1:0] qa_x,
    output logic signed [DATA_WIDTH-1:0] qa_y,
    output logic                         qa_start,
    input  logic                         qa_ready,
    input  logic signed [DATA_WIDTH-1:0] qa_result,
    input  logic                         qa_done,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic                         out_wr_en,
    input  logic                         out_full
);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    function automatic sample_t deq_mul(input sample_t a, input sample_t b);
        sample_t prod;
        prod = a * b;
        return prod >>> BITS;
    endfunction

    state_t  state;
    state_t  state_nxt;
    sample_t cur_real_p0;
    sample_t cur_imag_p0;
    sample_t prev_real;
    sample_t prev_imag;
    sample_t conj_real;
    sample_t conj_imag;
    sample_t angle_p2;

    demod_cmul #(
        .DATA_WIDTH(DATA_WIDTH),
        .BITS      (BITS)
    ) u_cmul (
        .prev_real(prev_real),
        .prev_imag(prev_imag),
        .cur_real (cur_real_p0),
        .cur_imag (cur_imag_p0),
        .conj_real(conj_real),
        .conj_imag(conj_imag)
    );

    // The pop is gated by reset_n so a held reset never drains the FIFO.
    always_comb begin
        state_nxt = state;
        in_rd_en  = 1'b0;
        case (state)
            IDLE: begin
                if (!in_empty) begin
                    in_rd_en  = reset_n;
                    state_nxt = MULT;
                end
            end
            MULT:  state_nxt = ISSUE;
            ISSUE: if (qa_ready) state_nxt = WAIT;
            WAIT:  if (qa_done) state_nxt = SCALE;
            SCALE: state_nxt = WRITE;
            WRITE: if (!out_full) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            prev_real <= '0;
            prev_imag <= '0;
            qa_x      <= '0;
            qa_y      <= '0;
            qa_start  <= 1'b0;
            out_data  <= '0;
            out_wr_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            qa_start  <= (state == ISSUE) && qa_ready;
            out_wr_en <= (state == WRITE) && !out_full;
            // p0 -> p1: conjugate product held on qa_x/qa_y until the next sample
            if (state == MULT) begin
                qa_x      <= conj_real;
                qa_y      <= conj_imag;
                prev_real <= cur_real_p0;
                prev_imag <= cur_imag_p0;
            end
            // p2 -> output: gain scaling of the captured angle
            if (state == SCALE) begin
                out_data <= deq_mul(GAIN, angle_p2);
            end
        end
    end

    // input -> p0 sample latch; qarctan -> p2 angle capture
    always_ff @(posedge clk) begin
        if (in_rd_en) begin
            cur_real_p0 <= in_real;
            cur_imag_p0 <= in_imag;
        end
        if ((state == WAIT) && qa_done) begin
            angle_p2 <= qa_result;
        end
    end

endmodule

// File: tb/tb_fm_demod.sv
// Directed and random bench for fm_demod with a behavioural qarctan stub and
// queue-based scoreboards for the qarctan operands and the output samples.
module tb_fm_demod;

    localparam logic signed [31:0] GAIN = 32'sh000002F5;

    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } pair_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic signed [31:0] in_real;
    logic signed [31:0] in_imag;
    logic               in_empty;
    logic               in_rd_en;
    logic signed [31:0] qa_x;
    logic signed [31:0] qa_y;
    logic               qa_start;
    logic               qa_ready;
    logic signed [31:0] qa_result;
    logic               qa_done;
    logic signed [31:0] out_data;
    logic               out_wr_en;
    logic               out_full;

    logic               tb_ready;
    logic               stall_in;
    logic               lat_rand;
    int                 lat_fix;
    int                 cnt;
    logic signed [31:0] stub_res;

    pair_t              in_q[$];
    pair_t              exp_xy_q[$];
    logic signed [31:0] exp_out_q[$];
    logic signed [31:0] ang_q[$];
    logic signed [31:0] prev_re;
    logic signed [31:0] prev_im;

    int  checks = 0;
    int  passed = 0;
    int  fails = 0;
    int  pops = 0;
    int  pushes = 0;
    int  starts = 0;
    time last_pop_t = 0;
    time last_push_t = 0;

    always #5 clk = ~clk;

    assign qa_ready  = tb_ready && (cnt == 0);
    assign qa_done   = (cnt == 1);
    assign qa_result = stub_res;

    fm_demod dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_real  (in_real),
        .in_imag  (in_imag),
        .in_empty (in_empty),
        .in_rd_en (in_rd_en),
        .qa_x     (qa_x),
        .qa_y     (qa_y),
        .qa_start (qa_start),
        .qa_ready (qa_ready),
        .qa_result(qa_result),
        .qa_done  (qa_done),
        .out_data (out_data),
        .out_wr_en(out_wr_en),
        .out_full (out_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] deq_mul(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        logic signed [31:0] p;
        p = a * b;
        return p >>> 10;
    endfunction

    function automatic logic signed [31:0] stub_angle(input logic signed [31:0] x,
                                                      input logic signed [31:0] y);
        return x - (y <<< 1);
    endfunction

    task automatic push_sample(input logic signed [31:0] re, input logic signed [31:0] im,
                               input logic ovr, input logic signed [31:0] ang,
                               input logic fixed, input logic signed [31:0] exp_o);
        pair_t              xy;
        logic signed [31:0] a;
        xy.re = deq_mul(prev_re, re) - deq_mul(-prev_im, im);
        xy.im = deq_mul(prev_re, im) + deq_mul(-prev_im, re);
        exp_xy_q.push_back(xy);
        a = ovr ? ang : stub_angle(xy.re, xy.im);
        if (ovr) ang_q.push_back(ang);
        exp_out_q.push_back(fixed ? exp_o : deq_mul(GAIN, a));
        prev_re = re;
        prev_im = im;
        in_q.push_back({re, im});
    endtask

    task automatic push_ovr(input logic signed [31:0] re, input logic signed [31:0] im,
                            input logic signed [31:0] ang, input logic signed [31:0] exp_o);
        push_sample(re, im, 1'b1, ang, 1'b1, exp_o);
    endtask

    task automatic push_model(input logic signed [31:0] re, input logic signed [31:0] im);
        push_sample(re, im, 1'b0, 32'sd0, 1'b0, 32'sd0);
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while ((exp_out_q.size() != 0 || in_q.size() != 0) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check_bit({tag, "_drained"}, exp_out_q.size() == 0, 1'b1);
    endtask

    // Input FIFO model (show-ahead) with optional stall
    initial begin
        in_empty = 1'b1;
        in_real  = '0;
        in_imag  = '0;
        forever begin
            logic p;
            logic e;
            @(posedge clk);
            p = in_rd_en;
            e = in_empty;
            #1;
            if (p) begin
                check_bit("pop_while_empty", e, 1'b0);
                if (in_q.size() != 0) void'(in_q.pop_front());
                pops++;
                last_pop_t = $time - 1;
            end
            in_empty = (in_q.size() == 0) || stall_in;
            if (in_q.size() != 0) begin
                in_real = in_q[0].re;
                in_imag = in_q[0].im;
            end
        end
    end

    // qarctan stub: done arrives a configurable number of cycles after start
    initial begin
        cnt      = 0;
        stub_res = '0;
        forever begin
            logic s;
            @(posedge clk);
            s = qa_start;
            #1;
            if (!reset_n) begin
                cnt = 0;
            end else if (s) begin
                cnt = lat_rand ? int'($urandom_range(1, 4)) : lat_fix;
                if (ang_q.size() != 0) stub_res = ang_q.pop_front();
                else stub_res = stub_angle(qa_x, qa_y);
            end else if (cnt > 0) begin
                cnt--;
            end
        end
    end

    // Output-side scoreboard and operand stability monitor
    initial begin
        pair_t              e;
        logic signed [31:0] hold_x;
        logic signed [31:0] hold_y;
        hold_x = '0;
        hold_y = '0;
        forever begin
            @(negedge clk);
            if (qa_start) begin
                starts++;
                check_bit("xy_expected", exp_xy_q.size() != 0, 1'b1);
                if (exp_xy_q.size() != 0) begin
                    e = exp_xy_q.pop_front();
                    check("qa_x", qa_x, e.re);
                    check("qa_y", qa_y, e.im);
                end
                hold_x = qa_x;
                hold_y = qa_y;
            end
            if (qa_done && reset_n) begin
                check("qa_x_at_done", qa_x, hold_x);
                check("qa_y_at_done", qa_y, hold_y);
            end
            if (out_wr_en) begin
                pushes++;
                last_push_t = $time;
                check_bit("push_expected", exp_out_q.size() != 0, 1'b1);
                if (exp_out_q.size() != 0) check("out_data", out_data, exp_out_q.pop_front());
            end
        end
    end

    initial begin
        int                 lat;
        int                 p0;
        int                 pu0;
        int                 s0;
        int                 c;
        logic signed [31:0] hx;
        logic signed [31:0] hy;
        logic signed [31:0] od;

        reset_n  = 1'b0;
        tb_ready = 1'b1;
        out_full = 1'b0;
        stall_in = 1'b0;
        lat_rand = 1'b0;
        lat_fix  = 2;
        prev_re  = '0;
        prev_im  = '0;

        repeat (3) @(negedge clk);
        check("rst_out_data", out_data, 32'h0);
        check("rst_qa_x", qa_x, 32'h0);
        check("rst_qa_y", qa_y, 32'h0);
        check_bit("rst_qa_start", qa_start, 1'b0);
        check_bit("rst_out_wr_en", out_wr_en, 1'b0);
        check_bit("rst_in_rd_en", in_rd_en, 1'b0);
        reset_n = 1'b1;
        @(negedge clk);

        // First sample after reset sees prev=0, so qarctan returns its zero-case angle
        push_ovr(32'sd1024, 32'sd0, 32'sh648, 32'sh4A4);
        push_ovr(32'sd1024, 32'sd0, 32'sd2, 32'sd1);
        drain("t1");
        lat = int'((last_push_t - last_pop_t - 5) / 10) + 1;
        check("t1_latency", 32'(lat), 32'(6 + lat_fix));

        // Gain scaling, positive and negative angles (floor on the shift)
        push_ovr(32'sd5, 32'sd7, 32'sh100, 32'sd189);
        push_ovr(-32'sd3, 32'sd9, 32'shFFFFFF00, 32'shFFFFFF42);
        drain("t2");

        // qarctan not ready: no start, operands held
        tb_ready = 1'b0;
        p0 = pops;
        push_model(32'sd300, -32'sd200);
        for (c = 0; c < 100 && pops == p0; c++) @(negedge clk);
        check_bit("t3_popped", pops != p0, 1'b1);
        @(negedge clk);
        hx = qa_x;
        hy = qa_y;
        s0 = starts;
        repeat (20) begin
            @(negedge clk);
            check_bit("t3_no_start", qa_start, 1'b0);
            check("t3_x_stable", qa_x, hx);
            check("t3_y_stable", qa_y, hy);
        end
        tb_ready = 1'b1;
        @(negedge clk);
        check_bit("t3_start_pulse", qa_start, 1'b1);
        @(negedge clk);
        check_bit("t3_start_one_cycle", qa_start, 1'b0);
        drain("t3");
        check("t3_start_count", 32'(starts), 32'(s0 + 1));

        // Output FIFO full while in WRITE
        out_full = 1'b1;
        p0 = pops;
        push_model(32'sd1000, 32'sd1000);
        push_model(-32'sd50, 32'sd77);
        for (c = 0; c < 100 && pops == p0; c++) @(negedge clk);
        check_bit("t4_popped", pops != p0, 1'b1);
        repeat (12) @(negedge clk);
        od  = out_data;
        p0  = pops;
        pu0 = pushes;
        repeat (10) begin
            @(negedge clk);
            check_bit("t4_no_wr", out_wr_en, 1'b0);
            check_bit("t4_no_rd", in_rd_en, 1'b0);
            check("t4_out_stable", out_data, od);
        end
        check("t4_no_pop", 32'(pops), 32'(p0));
        out_full = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_one_push", 32'(pushes), 32'(pu0 + 1));
        drain("t4");

        // Reset while waiting on qarctan aborts the sample
        lat_fix = 8;
        s0 = starts;
        push_model(32'sd123, 32'sd456);
        for (c = 0; c < 200 && starts == s0; c++) @(negedge clk);
        check_bit("t5_start_seen", starts != s0, 1'b1);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        pu0 = pushes;
        s0  = starts;
        exp_xy_q.delete();
        exp_out_q.delete();
        ang_q.delete();
        in_q.delete();
        prev_re = '0;
        prev_im = '0;
        push_ovr(32'sd2048, 32'sd0, 32'sh648, 32'sh4A4);
        push_ovr(32'sd2048, 32'sd0, 32'sd2, 32'sd1);
        p0 = pops;
        repeat (4) begin
            @(negedge clk);
            check_bit("t5_rst_rd", in_rd_en, 1'b0);
            check_bit("t5_rst_start", qa_start, 1'b0);
            check_bit("t5_rst_wr", out_wr_en, 1'b0);
        end
        check("t5_rst_out_data", out_data, 32'h0);
        check("t5_no_pop_in_reset", 32'(pops), 32'(p0));
        lat_fix = 2;
        reset_n = 1'b1;
        drain("t5");
        check("t5_pushes", 32'(pushes), 32'(pu0 + 2));
        check("t5_starts", 32'(starts), 32'(s0 + 2));

        // Random stream with FIFO and qarctan stalls
        lat_rand = 1'b1;
        for (int k = 0; k < 1000; k++) push_model($urandom, $urandom);
        for (c = 0; c < 60000 && exp_out_q.size() != 0; c++) begin
            @(negedge clk);
            stall_in = ($urandom_range(0, 3) == 0);
            out_full = ($urandom_range(0, 4) == 0);
            tb_ready = ($urandom_range(0, 4) != 0);
        end
        stall_in = 1'b0;
        out_full = 1'b0;
        tb_ready = 1'b1;
        check_bit("t6_drained", exp_out_q.size() == 0, 1'b1);
        repeat (5) @(negedge clk);
        check("push_per_pop", 32'(pushes), 32'(pops - 1));
        check("start_per_pop", 32'(starts), 32'(pops));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
